// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forwarding encodings and MDU state type shared by the hazard unit
package hazard_pkg;

   localparam logic [1:0] FWD_RF2 = 2'b00;
   localparam logic [1:0] FWD_W2  = 2'b01;
   localparam logic [1:0] FWD_M2  = 2'b10;

   localparam logic [2:0] FWD_RF3 = 3'b000;
   localparam logic [2:0] FWD_W3  = 3'b001;
   localparam logic [2:0] FWD_M3  = 3'b010;
   localparam logic [2:0] FWD_E3  = 3'b100;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mduState_e;

endpackage

// File: rtl/mdu_busy_tracker.sv
// rtl/mdu_busy_tracker.sv - counts multiply/divide busy cycles after issue
module mdu_busy_tracker
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

   mduState_e       state;
   logic [CW-1:0]   cnt;

   // A start while busy reloads the counter so the newest operation governs the stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt   <= is_div ? DIV_LOAD : MUL_LOAD;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (start) begin
                  cnt <= is_div ? DIV_LOAD : MUL_LOAD;
               end else if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_unit_mdu.sv
// rtl/hazard_unit_mdu.sv - 5-stage MIPS hazard unit with forwarding, stalls, flush and MDU tracking
module hazard_unit_mdu
   import hazard_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] RsE,
   input  logic [REG_AW-1:0] RtE,
   input  logic [REG_AW-1:0] WriteRegE,
   input  logic [REG_AW-1:0] WriteRegM,
   input  logic [REG_AW-1:0] WriteRegW,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemtoRegE,
   input  logic              MemtoRegM,
   input  logic              BranchD,
   input  logic              PCSrcD,
   input  logic              MduUseD,
   input  logic              MduStartE,
   input  logic              MduIsDivE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic [2:0]        ForwardAD,
   output logic [2:0]        ForwardBD,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushE,
   output logic              FlushD,
   output logic              MduBusy,
   output logic [CNT_W-1:0]  StallCount
);

   function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst,
                                input logic we);
      return we && (src != '0) && (src == dst);
   endfunction

   function automatic logic [1:0] fwdE(input logic [REG_AW-1:0] src);
      if (hit(src, WriteRegM, RegWriteM))      return FWD_M2;
      else if (hit(src, WriteRegW, RegWriteW)) return FWD_W2;
      else                                     return FWD_RF2;
   endfunction

   // A load in E has no data yet, so it is never a forwarding source for the branch compare.
   function automatic logic [2:0] fwdD(input logic [REG_AW-1:0] src);
      if (hit(src, WriteRegE, RegWriteE && !MemtoRegE)) return FWD_E3;
      else if (hit(src, WriteRegM, RegWriteM))          return FWD_M3;
      else if (hit(src, WriteRegW, RegWriteW))          return FWD_W3;
      else                                              return FWD_RF3;
   endfunction

   logic lwStall, branchStall, mduStall, stall;

   always_comb begin
      ForwardAE   = fwdE(RsE);
      ForwardBE   = fwdE(RtE);
      ForwardAD   = fwdD(RsD);
      ForwardBD   = fwdD(RtD);
      lwStall     = MemtoRegE && (hit(RsD, WriteRegE, RegWriteE) || hit(RtD, WriteRegE, RegWriteE));
      branchStall = BranchD && MemtoRegM &&
                    (hit(RsD, WriteRegM, RegWriteM) || hit(RtD, WriteRegM, RegWriteM));
      mduStall    = MduUseD && (MduBusy || MduStartE);
      stall       = lwStall || branchStall || mduStall;
   end

   assign StallF = stall;
   assign StallD = stall;
   assign FlushE = stall;
   assign FlushD = PCSrcD && !stall;

   mdu_busy_tracker #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) uTracker (
      .clk    (clk),
      .reset  (reset),
      .start  (MduStartE),
      .is_div (MduIsDivE),
      .busy   (MduBusy)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         StallCount <= '0;
      end else if (stall && (StallCount != '1)) begin
         StallCount <= StallCount + 1'b1;
      end
   end

endmodule
